// File: rtl/nibble_serializer.sv
// nibble_serializer: accepts a packed word of WIDTH 4-bit nibbles and emits
// it one nibble per accepted output beat, LSB-first by default.
// Optional build macro NIBBLE_SERIALIZER_MSB_FIRST_EN switches the emission
// order to MSB-first. Interface, timing and handshake are identical in both builds.
//
// Handshake rules, both ports: a transfer happens on a rising clk edge where
// valid & ready are both 1. The producer drives valid without looking at ready.
// The consumer may drive ready combinationally from valid. Here, out_data and
// out_last are held stable while out_valid=1 and out_ready=0. in_ready is low
// during reset. It is high in IDLE. While shifting, in_ready = out_ready & out_last,
// so the next word is captured on the same edge as the final nibble and no
// bubble appears.
module nibble_serializer #(
  parameter int         WIDTH       = 8,
  parameter logic [3:0] IDLE_NIBBLE = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0][3:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int                IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WIDTH-1:0][3:0] word_q, word_d;

  logic                  shifting;
  logic                  in_hs;
  logic                  out_hs;
  logic [IDX_W-1:0]      pos;

  assign shifting = (state_q == ST_SHIFT);

  // idx counts beats already sent. pos maps that beat count to a nibble position.
`ifdef NIBBLE_SERIALIZER_MSB_FIRST_EN
  assign pos = LAST_IDX - idx_q;
`else
  assign pos = idx_q;
`endif

  // Output side: the nibble is shown only while a word is held. Otherwise the
  // idle pattern is driven.
  always_comb begin
    out_valid = shifting;
    out_last  = shifting && (idx_q == LAST_IDX);
    out_data  = shifting ? word_q[pos] : IDLE_NIBBLE;
    busy      = shifting;
  end

  // Input side: a new word may enter when idle, or when the final nibble of
  // the current word leaves this cycle.
  always_comb begin
    in_ready = !reset && (!shifting || (out_ready && out_last));
    in_hs    = in_valid && in_ready;
    out_hs   = out_valid && out_ready;
  end

  // Next-state logic for the IDLE/SHIFT machine, the beat index and the held word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          word_d  = in_data;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (out_hs) begin
          if (out_last) begin
            idx_d = '0;
            if (in_hs) begin
              word_d  = in_data;
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers. Reset drops any partially sent word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed plus randomized bench for nibble_serializer (WIDTH=8).
// The emission order follows NIBBLE_SERIALIZER_MSB_FIRST_EN, the same as the design.
module tb_nibble_serializer;

  localparam int         WIDTH = 8;
  localparam logic [3:0] IDLE  = 4'hF;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0][3:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_data;
  logic                  out_last;
  logic                  busy;

  nibble_serializer #(.WIDTH(WIDTH), .IDLE_NIBBLE(IDLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {last, nibble} in emission order
  logic [4:0] exp_q[$];
  int         errors;
  int         checks;

  bit         rand_ready;
  bit         chk_in_ready;
  bit         prev_stall;
  logic [3:0] prev_data;
  logic       prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // nibble emitted at beat i of word w
  function automatic logic [3:0] nib_at(input logic [WIDTH*4-1:0] w, input int i);
    int p;
`ifdef NIBBLE_SERIALIZER_MSB_FIRST_EN
    p = WIDTH - 1 - i;
`else
    p = i;
`endif
    return w[p*4 +: 4];
  endfunction

  task automatic push_word(input logic [WIDTH*4-1:0] w);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back({(i == WIDTH - 1), nib_at(w, i)});
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge.
  task automatic tick();
    bit         hs_in;
    logic [4:0] e;
    @(negedge clk);
    if (!reset && prev_stall) begin
      check("stall_data", out_data, prev_data);
      check("stall_last", out_last, prev_last);
    end
    if (!reset && out_valid === 1'b0) begin
      check("idle_data", out_data, IDLE);
      check("idle_last", out_last, 1'b0);
    end
    if (chk_in_ready && out_valid === 1'b1)
      check("in_ready_shift", in_ready, out_last & out_ready);
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_nibble", {out_last, out_data}, 5'h00 + 5'h1F + 5'h01);
      end else begin
        e = exp_q.pop_front();
        check("nibble", {out_last, out_data}, e);
      end
    end
    hs_in      = in_valid && (in_ready === 1'b1);
    prev_stall = !reset && (out_valid === 1'b1) && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    @(posedge clk);
    #1;
    if (hs_in) in_valid = 1'b0;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // driver: present a word and hold it until accepted
  task automatic send_word(input logic [WIDTH*4-1:0] w);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    push_word(w);
    n = 0;
    while (in_valid && n < 200) begin
      tick();
      n++;
    end
    if (in_valid) begin
      check("accept_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    logic [WIDTH*4-1:0] w;
    errors       = 0;
    checks       = 0;
    rand_ready   = 1'b0;
    chk_in_ready = 1'b0;
    prev_stall   = 1'b0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;

    // reset held for 3 cycles
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'hF);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);

    // single word, sink always ready
    out_ready = 1'b1;
    send_word(32'h76543210);
    check("latency_valid", out_valid, 1'b1);
    check("latency_data", out_data, nib_at(32'h76543210, 0));
    drain(n);
    check("single_cycles", 32'(n), 32'd8);
    check("single_idle_valid", out_valid, 1'b0);
    check("single_idle_busy", busy, 1'b0);
    check("single_idle_in_ready", in_ready, 1'b1);

    // backpressure with out_ready pattern 1,0,0,1
    chk_in_ready = 1'b1;
    send_word(32'h76543210);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      out_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk_in_ready = 1'b0;
    out_ready    = 1'b1;
    tick();
    check("bp_idle", busy, 1'b0);

    // back-to-back words: 16 contiguous nibbles
    send_word(32'h76543210);
    in_data  = 32'hFEDCBA98;
    in_valid = 1'b1;
    push_word(32'hFEDCBA98);
    drain(n);
    check("b2b_cycles", 32'(n), 32'd16);
    check("b2b_accepted", in_valid, 1'b0);
    tick();
    check("b2b_idle", out_valid, 1'b0);

    // held input changes without a handshake must be ignored
    send_word(32'hA5C3_1E2D);
    in_data = 32'h0BAD_F00D;
    drain(n);
    check("ignore_cycles", 32'(n), 32'd8);

    // random words, random sink stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = $urandom;
      send_word(w);
    end
    drain(n);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    tick();
    check("rand_idle", busy, 1'b0);

    // reset in the middle of a word
    send_word(32'h76543210);
    repeat (3) tick();
    check("mid_pending", 32'(exp_q.size()), 32'd5);
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", out_data, 4'hF);
    check("mid_rst_last", out_last, 1'b0);
    out_ready = 1'b1;
    repeat (10) tick();
    check("mid_rst_quiet", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of 4-bit nibbles per input word; legal range WIDTH >= 2.
REQ-002 The block SHALL have parameter IDLE_NIBBLE, default 4'hF: value driven on out_data while no nibble is valid.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data holds a word.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 The block SHALL have port in_data, input, [WIDTH-1:0][3:0]: packed word of WIDTH nibbles.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a nibble.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the sink accepts the nibble.
REQ-010 The block SHALL have port out_data, output, [3:0]: current nibble.
REQ-011 The block SHALL have port out_last, output, 1 bit: current nibble is the final nibble of its word.
REQ-012 The block SHALL have port busy, output, 1 bit: a word is being serialized.

Function
REQ-013 The block SHALL implement two states: IDLE (no word held) and SHIFT (word held, nibble index idx valid); idx width SHALL be $clog2(WIDTH).
REQ-014 An input handshake SHALL be in_valid & in_ready; an output handshake SHALL be out_valid & out_ready.
REQ-015 in_ready SHALL be 1 in IDLE; in SHIFT, in_ready SHALL equal out_ready & out_last (combinational), and 0 otherwise.
REQ-016 On an input handshake the block SHALL register in_data, set idx=0, and enter SHIFT, with out_valid=1 and the first nibble on out_data on the next cycle: latency exactly 1 cycle.
REQ-017 In SHIFT, out_data SHALL be the registered nibble at position idx (LSB-first: nibble 0 first), with out_valid=1.
REQ-018 out_data, out_last and idx SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 On an output handshake with idx < WIDTH-1, idx SHALL increment by 1.
REQ-020 out_last SHALL be 1 exactly when out_valid=1 and idx == WIDTH-1.
REQ-021 On an output handshake with out_last=1 and a simultaneous input handshake, the block SHALL capture the new word, set idx=0, and remain in SHIFT, with no bubble cycle.
REQ-022 On an output handshake with out_last=1 and no input handshake, the block SHALL enter IDLE with out_valid=0 and out_data=IDLE_NIBBLE.
REQ-023 busy SHALL be 1 exactly in SHIFT.
REQ-024 Changes on in_data without an input handshake SHALL be ignored.
REQ-025 Sustained throughput with out_ready=1 SHALL be one nibble per cycle, i.e. one word per WIDTH cycles.

Reset
REQ-026 While reset=1 at a clock edge, the next state SHALL be IDLE, with idx=0, out_valid=0, out_last=0, busy=0 and out_data=IDLE_NIBBLE; in_ready SHALL be 0 during the reset cycle.
REQ-027 A reset asserted mid-word SHALL discard the remaining nibbles; after reset deassertion no nibble of the discarded word SHALL appear.

Configuration
REQ-028 When macro NIBBLE_SERIALIZER_MSB_FIRST_EN is defined, nibble order SHALL be MSB-first: nibble WIDTH-1 is emitted first and nibble 0 last, with out_last flagging nibble 0.
REQ-029 When NIBBLE_SERIALIZER_MSB_FIRST_EN is undefined, order SHALL be LSB-first per REQ-017; the interface, timing and handshake SHALL be identical in both builds.

Verification
REQ-030 Reset check: hold reset for 3 cycles -> out_valid=0, out_data=4'hF, busy=0; then in_ready=1 one cycle after release.
REQ-031 Single word: WIDTH=8, in_data=32'h76543210, out_ready=1 -> out_data 0,1,...,7 on 8 consecutive cycles starting 1 cycle after accept; out_last only on 7; then IDLE.
REQ-032 Backpressure: same word, out_ready toggled 1,0,0,1,... -> each nibble held unchanged while stalled; sequence intact; in_ready=0 until the final handshake.
REQ-033 Back-to-back: words 32'h76543210 then 32'hFEDCBA98, both presented early, out_ready=1 -> 16 contiguous nibbles 0..F, no gap, out_last at 7 and F.
REQ-034 Reset mid-word: assert reset after the third nibble of 32'h76543210 -> the next cycle is IDLE; the nibbles 3..7 never appear.
REQ-035 MSB build: define NIBBLE_SERIALIZER_MSB_FIRST_EN, send 32'h76543210 -> out_data 7,6,...,0; out_last on 0.
